// File: rtl/ex_hilo_seq_pkg.sv
// Shared definitions for the HI/LO sequencer: op codes, FSM states, widths and result fields.
package hilo_seq_pkg;

  localparam int HILO_DATA_W = 32;
  localparam int DIV_CYCLES  = HILO_DATA_W;
  localparam int OP_W        = 3;

  localparam int LO_LSB = 0;
  localparam int LO_MSB = HILO_DATA_W - 1;
  localparam int HI_LSB = HILO_DATA_W;
  localparam int HI_MSB = 2 * HILO_DATA_W - 1;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 3'd0,
    OP_DIV   = 3'd1,
    OP_DIVU  = 3'd2,
    OP_MADD  = 3'd3,
    OP_MADDU = 3'd4,
    OP_MSUB  = 3'd5,
    OP_MSUBU = 3'd6
  } hilo_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV_ZERO,
    ST_DIV_RUN,
    ST_MAC_ACC,
    ST_DONE
  } hilo_state_e;

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mac(input logic [OP_W-1:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/ex_hilo_seq_if.sv
// EX-stage <-> HI/LO sequencer request/response bundle; master is EX, slave is the sequencer.
interface hilo_seq_if #(parameter int DATA_W = 32);
  import hilo_seq_pkg::*;

  logic                  start_i;
  logic [OP_W-1:0]       op_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic [2*DATA_W-1:0]   hilo_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;
  logic                  busy_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
    input  result_o, ready_o, stallreq_o, busy_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, hilo_i, annul_i,
    output result_o, ready_o, stallreq_o, busy_o
  );

endinterface

// File: rtl/ex_hilo_seq_div_step.sv
// One restoring-division iteration on a remainder/quotient pair.
// Latency: combinational. Backpressure: none, the caller sequences iterations.
module div_step
  import hilo_seq_pkg::*;
#(
  parameter int W = HILO_DATA_W
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvs,
  output logic [W-1:0] rem_nxt,
  output logic [W-1:0] quo_nxt
);

  // Shifted remainder needs one extra bit: rem < dvs, so 2*rem+1 can exceed W bits.
  logic [W:0] trial;
  logic [W:0] diff;

  assign trial = {rem, quo[W-1]};
  assign diff  = trial - {1'b0, dvs};

  always_comb begin
    rem_nxt = trial[W-1:0];
    quo_nxt = {quo[W-2:0], 1'b0};
    if (trial >= {1'b0, dvs}) begin
      rem_nxt = diff[W-1:0];
      quo_nxt = {quo[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/ex_hilo_seq.sv
// Multi-cycle HI/LO sequencer (div/divu, madd/msub variants when HILO_SEQ_MAC_EN is defined).
// Latency: div 33 cycles, div-by-zero and mac 2 cycles; ready_o pulses one cycle in DONE.
// Backpressure: holds stallreq_o until the result is ready; annul_i or a dropped start_i aborts.
module ex_hilo_seq
  import hilo_seq_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W
) (
  input  logic      clk,
  input  logic      rst,
  hilo_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  hilo_state_e         state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rem, quo, dvs;
  logic [DATA_W-1:0]   rem_step, quo_step;
  logic                neg_quo, neg_rem;
  logic [2*DATA_W-1:0] result_q, result_nxt;
  logic                op_div, op_mac, go, abort;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;

  assign op_div = is_div(bus.op_i);
  assign go     = (state == ST_IDLE) && bus.start_i && !bus.annul_i;
  // EX must hold start_i while stalled; losing it mid-operation is handled like a flush.
  assign abort  = bus.annul_i || ((state != ST_IDLE) && !bus.start_i);

  assign a_neg = (bus.op_i == OP_DIV) && bus.opdata1_i[DATA_W-1];
  assign b_neg = (bus.op_i == OP_DIV) && bus.opdata2_i[DATA_W-1];
  assign a_mag = a_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign b_mag = b_neg ? -bus.opdata2_i : bus.opdata2_i;

`ifdef HILO_SEQ_MAC_EN
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] mac_prod;
  logic [2*DATA_W-1:0] ext_a, ext_b, raw_prod;
  logic                mul_signed;

  assign op_mac = is_mac(bus.op_i);

  // Sign/zero-extending to the full width makes a truncated product correct for both cases.
  always_comb begin
    mul_signed = (bus.op_i == OP_MADD) || (bus.op_i == OP_MSUB);
    ext_a      = {{DATA_W{mul_signed & bus.opdata1_i[DATA_W-1]}}, bus.opdata1_i};
    ext_b      = {{DATA_W{mul_signed & bus.opdata2_i[DATA_W-1]}}, bus.opdata2_i};
    raw_prod   = ext_a * ext_b;
    mac_prod   = ((bus.op_i == OP_MSUB) || (bus.op_i == OP_MSUBU)) ? -raw_prod : raw_prod;
  end
`else
  logic unused_hilo;

  assign op_mac      = 1'b0;
  assign unused_hilo = ^bus.hilo_i;
`endif

  div_step #(.W(DATA_W)) u_div_step (
    .rem     (rem),
    .quo     (quo),
    .dvs     (dvs),
    .rem_nxt (rem_step),
    .quo_nxt (quo_step)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (go && op_div) begin
          state_nxt = (bus.opdata2_i == '0) ? ST_DIV_ZERO : ST_DIV_RUN;
        end else if (go && op_mac) begin
          state_nxt = ST_MAC_ACC;
        end
      end
      ST_DIV_ZERO: state_nxt = ST_DONE;
      ST_DIV_RUN:  if (cnt == CNT_LAST) state_nxt = ST_DONE;
      ST_MAC_ACC:  state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  // Sign fix is folded into the final iteration's writeback.
  always_comb begin
    result_nxt = result_q;
    case (state)
      ST_DIV_ZERO: result_nxt = '0;
      ST_DIV_RUN: begin
        result_nxt[HI_MSB:HI_LSB] = neg_rem ? -rem_step : rem_step;
        result_nxt[LO_MSB:LO_LSB] = neg_quo ? -quo_step : quo_step;
      end
`ifdef HILO_SEQ_MAC_EN
      ST_MAC_ACC:  result_nxt = bus.hilo_i + prod;
`endif
      default:     result_nxt = result_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_quo  <= 1'b0;
      neg_rem  <= 1'b0;
      result_q <= '0;
    end else begin
      if (state_nxt == ST_DONE) result_q <= result_nxt;
      if ((state == ST_IDLE) && (state_nxt == ST_DIV_RUN)) begin
        rem     <= '0;
        quo     <= a_mag;
        dvs     <= b_mag;
        neg_quo <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        cnt     <= '0;
      end else if ((state == ST_DIV_RUN) && (state_nxt == ST_DIV_RUN)) begin
        rem <= rem_step;
        quo <= quo_step;
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

`ifdef HILO_SEQ_MAC_EN
  always_ff @(posedge clk) begin
    if (rst)                                             prod <= '0;
    else if ((state == ST_IDLE) && (state_nxt == ST_MAC_ACC)) prod <= mac_prod;
  end
`endif

  assign bus.result_o   = result_q;
  assign bus.ready_o    = (state == ST_DONE);
  assign bus.busy_o     = (state != ST_IDLE);
  assign bus.stallreq_o = ((state == ST_IDLE) && bus.start_i && (op_div || op_mac))
                        || (state == ST_DIV_ZERO) || (state == ST_DIV_RUN)
                        || (state == ST_MAC_ACC);

endmodule

// File: tb/tb_ex_hilo_seq.sv
// Directed bench for ex_hilo_seq; MAC vectors apply when HILO_SEQ_MAC_EN is defined.
module tb_ex_hilo_seq;
  import hilo_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  logic saw_ready;

  always #5 clk = ~clk;

  hilo_seq_if #(.DATA_W(32)) bus ();

  ex_hilo_seq #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.start_i   = 1'b0;
    bus.op_i      = OP_NONE;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.hilo_i    = '0;
    bus.annul_i   = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, {63'd0, bus.ready_o}, 64'd0);
    check({tag, "_stall"}, {63'd0, bus.stallreq_o}, 64'd0);
    check({tag, "_busy"},  {63'd0, bus.busy_o}, 64'd0);
  endtask

  // Starts an op in the current (IDLE) cycle, holds start until ready, ends in the cycle after DONE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hilo, input int lat,
                        input logic [63:0] exp);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.hilo_i    = hilo;
    #1;
    for (int k = 0; k < lat; k++) begin
      check({tag, "_stall_rdy"}, {62'd0, bus.stallreq_o, bus.ready_o}, 64'd2);
      tick();
    end
    check({tag, "_done_stall_rdy"}, {62'd0, bus.stallreq_o, bus.ready_o}, 64'd1);
    check({tag, "_result"}, bus.result_o, exp);
    idle_inputs();
    tick();
    check({tag, "_hold"}, bus.result_o, exp);
    check({tag, "_after_busy_rdy"}, {62'd0, bus.busy_o, bus.ready_o}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    check("reset_result", bus.result_o, 64'd0);
    check_quiet("reset");
    rst = 1'b0;
    tick();

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 64'd0, 33, 64'h00000002_0000000E);
    run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 64'd0, 33, 64'hFFFFFFFF_FFFFFFFD);
    run_op("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'd0, 33, 64'h00000000_80000000);
    run_op("div_by0", OP_DIV, 32'd5, 32'd0, 64'd0, 2, 64'd0);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 64'hDEADBEEF_CAFEF00D, 33, 64'h00000000_00000003);

    // annul_i wins over start_i in IDLE
    bus.start_i = 1'b1; bus.op_i = OP_DIVU; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
    bus.annul_i = 1'b1;
    tick();
    check("annul_prio_busy", {63'd0, bus.busy_o}, 64'd0);
    idle_inputs();
    tick();

    // annul in the 10th DIV_RUN cycle
    bus.start_i = 1'b1; bus.op_i = OP_DIV; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
    for (int k = 0; k < 10; k++) tick();
    check("annul_pre_busy", {63'd0, bus.busy_o}, 64'd1);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    tick();
    bus.annul_i = 1'b0;
    #1;
    check_quiet("annul_post");
    saw_ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      saw_ready = saw_ready | bus.ready_o;
    end
    check("annul_no_ready", {63'd0, saw_ready}, 64'd0);
    run_op("divu_after_annul", OP_DIVU, 32'd100, 32'd7, 64'd0, 33, 64'h00000002_0000000E);

    // start_i dropped mid-division acts as an abort
    bus.start_i = 1'b1; bus.op_i = OP_DIVU; bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd3;
    for (int k = 0; k < 4; k++) tick();
    bus.start_i = 1'b0;
    tick();
    check_quiet("drop_start");
    check("drop_start_result", bus.result_o, 64'h00000002_0000000E);

`ifdef HILO_SEQ_MAC_EN
    run_op("madd", OP_MADD, 32'd3, 32'hFFFFFFFC, 64'h00000000_0000000A, 2, 64'hFFFFFFFF_FFFFFFFE);
    run_op("msubu", OP_MSUBU, 32'd2, 32'd3, 64'h00000000_00000005, 2, 64'hFFFFFFFF_FFFFFFFF);

    bus.start_i = 1'b1; bus.op_i = OP_MADD; bus.opdata1_i = 32'd3; bus.opdata2_i = 32'd4;
    tick();
    check("rst_mac_busy", {63'd0, bus.busy_o}, 64'd1);
    rst = 1'b1;
    idle_inputs();
    tick();
    check("rst_mac_result", bus.result_o, 64'd0);
    check_quiet("rst_mac");
    rst = 1'b0;
    tick();
`else
    bus.start_i = 1'b1; bus.op_i = OP_MADD; bus.opdata1_i = 32'd3; bus.opdata2_i = 32'd4;
    #1;
    check("nomac_stall", {63'd0, bus.stallreq_o}, 64'd0);
    saw_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      saw_ready = saw_ready | bus.ready_o | bus.busy_o;
    end
    check("nomac_no_ready_busy", {63'd0, saw_ready}, 64'd0);
    idle_inputs();
    tick();

    bus.start_i = 1'b1; bus.op_i = OP_DIVU; bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd3;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    check("rst_div_result", bus.result_o, 64'd0);
    check_quiet("rst_div");
    rst = 1'b0;
    tick();
`endif

    run_op("divu_final", OP_DIVU, 32'd100, 32'd7, 64'd0, 33, 64'h00000002_0000000E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
